// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch types,
// exCtrl field positions and the iterative multiplier state type.
package ex_pkg;

    // aluOp encodings
    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSll   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluSlt   = 4'd8;
    localparam logic [3:0] AluPassB = 4'd9;
    localparam logic [3:0] AluPcAdd = 4'd10;
    localparam logic [3:0] AluMul   = 4'd11;

    // brType encodings
    localparam logic [1:0] BrNone = 2'b00;
    localparam logic [1:0] BrZero = 2'b01;
    localparam logic [1:0] BrNeg  = 2'b10;

    // exCtrl field positions
    localparam int unsigned ExAluSrcBit = 6;
    localparam int unsigned ExAluOpHi   = 5;
    localparam int unsigned ExAluOpLo   = 2;
    localparam int unsigned ExBrHi      = 1;
    localparam int unsigned ExBrLo      = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier (one multiplier bit per cycle).
// Optional macro MUL_EARLY_TERM_EN ends BUSY once no multiplier bits remain.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mul_state_e        state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mplier_next;
    logic              last_step;

    assign mplier_next = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
    assign last_step = (cnt_q == CntW'(DATA_W - 1)) || (mplier_next == '0);
`else
    assign last_step = (cnt_q == CntW'(DATA_W - 1));
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    busy_o    = 1'b1;
                    mcand_d   = a_i;
                    mplier_d  = b_i;
                    product_d = '0;
                    cnt_d     = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                busy_o = 1'b1;
                if (mplier_q[0]) begin
                    product_d = product_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_next;
                cnt_d    = cnt_q + CntW'(1);
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Never restarts from here, even if the MUL is still presented.
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    assign product_o = product_q;

endmodule

// File: rtl/ex_stage.sv
// Pipeline execute stage: operand forwarding, single-cycle ALU, branch resolve
// and a stalling iterative multiplier (see ex_mul_iter, macro MUL_EARLY_TERM_EN).
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pcIn,
    input  logic [DATA_W-1:0] rData1In,
    input  logic [DATA_W-1:0] rData2In,
    input  logic [DATA_W-1:0] immIn,
    input  logic [REG_AW-1:0] rsIn,
    input  logic [REG_AW-1:0] rtIn,
    input  logic [REG_AW-1:0] rdIn,
    input  logic [2:0]        wbCtrlIn,
    input  logic [1:0]        memCtrlIn,
    input  logic [6:0]        exCtrlIn,
    input  logic [REG_AW-1:0] exMemRd,
    input  logic              exMemRegWrite,
    input  logic [DATA_W-1:0] exMemResult,
    input  logic [REG_AW-1:0] memWbRd,
    input  logic              memWbRegWrite,
    input  logic [DATA_W-1:0] memWbData,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] storeData,
    output logic [REG_AW-1:0] rdOut,
    output logic [2:0]        wbCtrlOut,
    output logic [1:0]        memCtrlOut,
    output logic              branchTaken,
    output logic [DATA_W-1:0] branchTarget,
    output logic              stall
);

    logic [3:0]        alu_op;
    logic [1:0]        br_type;
    logic              alu_src_imm;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_res;
    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              br_cond;

    assign alu_op      = exCtrlIn[ExAluOpHi:ExAluOpLo];
    assign br_type     = exCtrlIn[ExBrHi:ExBrLo];
    assign alu_src_imm = exCtrlIn[ExAluSrcBit];

    // EX/MEM has priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rData1In;
        if (exMemRegWrite && (exMemRd != '0) && (exMemRd == rsIn)) begin
            fwd_a = exMemResult;
        end else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rsIn)) begin
            fwd_a = memWbData;
        end
    end

    always_comb begin
        fwd_b = rData2In;
        if (exMemRegWrite && (exMemRd != '0) && (exMemRd == rtIn)) begin
            fwd_b = exMemResult;
        end else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rtIn)) begin
            fwd_b = memWbData;
        end
    end

    assign op_b  = alu_src_imm ? immIn : fwd_b;
    assign shamt = op_b[4:0];

    // A MUL is not started while reset is held, keeping stall low during reset.
    assign mul_start = (alu_op == AluMul) && !rst;

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (mul_start),
        .a_i       (fwd_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:   alu_res = fwd_a + op_b;
            AluSub:   alu_res = fwd_a - op_b;
            AluAnd:   alu_res = fwd_a & op_b;
            AluOr:    alu_res = fwd_a | op_b;
            AluXor:   alu_res = fwd_a ^ op_b;
            AluSll:   alu_res = fwd_a << shamt;
            AluSrl:   alu_res = fwd_a >> shamt;
            AluSra:   alu_res = $unsigned($signed(fwd_a) >>> shamt);
            AluSlt:   alu_res = DATA_W'($signed(fwd_a) < $signed(op_b));
            AluPassB: alu_res = op_b;
            AluPcAdd: alu_res = pcIn + op_b;
            AluMul:   alu_res = mul_done ? mul_product : '0;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BrZero:  br_cond = (alu_res == '0);
            BrNeg:   br_cond = alu_res[DATA_W-1];
            default: br_cond = 1'b0;
        endcase
    end

    assign stall        = mul_busy;
    assign branchTaken  = br_cond && !stall;
    assign branchTarget = pcIn + immIn;
    assign aluResult    = alu_res;
    assign storeData    = fwd_b;
    assign rdOut        = rdIn;
    assign wbCtrlOut    = stall ? 3'b000 : wbCtrlIn;
    assign memCtrlOut   = stall ? 2'b00 : memCtrlIn;

endmodule
